// File: rtl/change_dispenser.sv
// Refund payout engine: converts a half-yuan balance into greedy coin offers
// (10 / 5 / 1 / 0.5 yuan), handshaking each coin with the hopper.
module change_dispenser #(
  parameter int ACK_TIMEOUT = 50,
  parameter int GAP_CYCLES  = 4,
  parameter int MAX_AMOUNT  = 199
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] amount,
  input  logic       clear,
  input  logic       out_ack,
  output logic       out_valid,
  output logic [3:0] out_coin,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       fault,
  output logic [7:0] remaining
);

  localparam int         TW    = $clog2(ACK_TIMEOUT + 1);
  localparam int         GW    = $clog2(GAP_CYCLES + 2);
  localparam logic [7:0] MAX_A = 8'(MAX_AMOUNT);

  typedef enum logic [2:0] {IDLE, SELECT, OFFER, GAP, FAULT} state_t;

  state_t          state, state_nx;
  logic [TW-1:0]   timer, timer_nx;
  logic [GW-1:0]   gap_cnt, gap_nx;
  logic            out_valid_nx, busy_nx, done_nx, err_nx, fault_nx;
  logic [3:0]      out_coin_nx;
  logic [7:0]      remaining_nx;

  // Largest denomination not exceeding the balance (half-yuan units 20/10/2/1).
  function automatic logic [3:0] pick_coin(input logic [7:0] bal);
    if (bal >= 8'd20)      return 4'b1000;
    else if (bal >= 8'd10) return 4'b0100;
    else if (bal >= 8'd2)  return 4'b0010;
    else                   return 4'b0001;
  endfunction

  function automatic logic [7:0] coin_value(input logic [3:0] coin);
    case (coin)
      4'b1000: return 8'd20;
      4'b0100: return 8'd10;
      4'b0010: return 8'd2;
      default: return 8'd1;
    endcase
  endfunction

  always_comb begin
    state_nx     = state;
    timer_nx     = timer;
    gap_nx       = gap_cnt;
    out_valid_nx = out_valid;
    out_coin_nx  = out_coin;
    busy_nx      = busy;
    done_nx      = 1'b0;
    err_nx       = 1'b0;
    fault_nx     = fault;
    remaining_nx = remaining;
    case (state)
      IDLE: begin
        if (start) begin
          if (amount > MAX_A) begin
            err_nx = 1'b1;
          end else if (amount == 8'd0) begin
            done_nx = 1'b1;
          end else begin
            remaining_nx = amount;
            busy_nx      = 1'b1;
            state_nx     = SELECT;
          end
        end
      end
      SELECT: begin
        if (remaining == 8'd0) begin
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end else begin
          out_coin_nx  = pick_coin(remaining);
          out_valid_nx = 1'b1;
          timer_nx     = '0;
          state_nx     = OFFER;
        end
      end
      OFFER: begin
        // An ack arriving on the timeout cycle still counts as accepted.
        if (out_ack) begin
          remaining_nx = remaining - coin_value(out_coin);
          out_valid_nx = 1'b0;
          out_coin_nx  = 4'b0000;
          gap_nx       = GW'(GAP_CYCLES);
          state_nx     = (GAP_CYCLES > 1) ? GAP : SELECT;
        end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
          out_valid_nx = 1'b0;
          out_coin_nx  = 4'b0000;
          busy_nx      = 1'b0;
          fault_nx     = 1'b1;
          state_nx     = FAULT;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      GAP: begin
        // The SELECT cycle is the last idle cycle of the gap.
        gap_nx = gap_cnt - 1'b1;
        if (gap_cnt <= GW'(2)) state_nx = SELECT;
      end
      FAULT: begin
        if (clear) begin
          fault_nx     = 1'b0;
          remaining_nx = 8'd0;
          state_nx     = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      timer     <= '0;
      gap_cnt   <= '0;
      out_valid <= 1'b0;
      out_coin  <= 4'b0000;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      fault     <= 1'b0;
      remaining <= 8'd0;
    end else begin
      state     <= state_nx;
      timer     <= timer_nx;
      gap_cnt   <= gap_nx;
      out_valid <= out_valid_nx;
      out_coin  <= out_coin_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      err       <= err_nx;
      fault     <= fault_nx;
      remaining <= remaining_nx;
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: greedy payout sequences, gaps,
// timeout fault, invalid amounts and asynchronous reset.
module tb_change_dispenser;

  localparam int ACK_TIMEOUT = 50;
  localparam int GAP_CYCLES  = 4;
  localparam int MAX_AMOUNT  = 199;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] amount;
  logic       clear;
  logic       out_ack;
  logic       out_valid;
  logic [3:0] out_coin;
  logic       busy;
  logic       done;
  logic       err;
  logic       fault;
  logic [7:0] remaining;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] exp_coins[$];
  logic [7:0] exp_rem[$];

  change_dispenser #(
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .GAP_CYCLES (GAP_CYCLES),
    .MAX_AMOUNT (MAX_AMOUNT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .amount   (amount),
    .clear    (clear),
    .out_ack  (out_ack),
    .out_valid(out_valid),
    .out_coin (out_coin),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .fault    (fault),
    .remaining(remaining)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [7:0] amt);
    start  = 1'b1;
    amount = amt;
    step();
    start  = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_coin"},  32'(out_coin),  0);
    chk({tag, "_busy"},  32'(busy),      0);
    chk({tag, "_done"},  32'(done),      0);
    chk({tag, "_err"},   32'(err),       0);
    chk({tag, "_fault"}, 32'(fault),     0);
    chk({tag, "_rem"},   32'(remaining), 0);
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (!done && guard < 40) begin
      step();
      guard++;
    end
    chk("done_pulse", 32'(done), 1);
    chk("done_gap", 32'(guard), GAP_CYCLES);
    chk("busy_done", 32'(busy), 0);
    chk("rem_done", 32'(remaining), 0);
    step();
    chk("done_clear", 32'(done), 0);
  endtask

  // Call right after the start edge; acks each offer in the cycle it is seen.
  task automatic run_coins(input bit noise);
    int guard;
    for (int i = 0; i < exp_coins.size(); i++) begin
      guard = 0;
      while (!out_valid && guard < 40) begin
        if (noise && i == 1 && guard == 1) begin
          start   = 1'b1;
          amount  = 8'd5;
          out_ack = 1'b1;
        end
        step();
        start   = 1'b0;
        out_ack = 1'b0;
        guard++;
      end
      if (i == 0) chk("first_latency", 32'(guard), 1);
      else        chk("gap_len", 32'(guard), GAP_CYCLES);
      chk("coin", 32'(out_coin), 32'(exp_coins[i]));
      chk("rem_offer", 32'(remaining), 32'(exp_rem[i]));
      chk("busy_offer", 32'(busy), 1);
      out_ack = 1'b1;
      step();
      out_ack = 1'b0;
      chk("valid_drop", 32'(out_valid), 0);
      chk("coin_drop", 32'(out_coin), 0);
      chk("rem_paid", 32'(remaining), 32'(exp_rem[i+1]));
    end
    wait_done();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    reset = 1'b0; start = 1'b0; amount = 8'd0; clear = 1'b0; out_ack = 1'b0;
    step();
    step();
    chk_all_zero("rst");
    reset = 1'b1;
    step();
    chk_all_zero("idle");

    // 37 = 20 + 10 + 2 + 2 + 2 + 1
    exp_coins = '{4'b1000, 4'b0100, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
    exp_rem   = '{8'd37, 8'd17, 8'd7, 8'd5, 8'd3, 8'd1, 8'd0};
    kick(8'd37);
    chk("busy_start", 32'(busy), 1);
    chk("valid_early", 32'(out_valid), 0);
    run_coins(1'b0);

    // Out-of-range amount
    kick(8'd200);
    chk("err_pulse", 32'(err), 1);
    chk("err_busy", 32'(busy), 0);
    chk("err_valid", 32'(out_valid), 0);
    step();
    chk("err_clear", 32'(err), 0);
    chk("err_valid2", 32'(out_valid), 0);

    // 199 = 9x20 + 10 + 4x2 + 1
    exp_coins = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000,
                  4'b1000, 4'b1000, 4'b0100, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
    exp_rem   = '{8'd199, 8'd179, 8'd159, 8'd139, 8'd119, 8'd99, 8'd79, 8'd59,
                  8'd39, 8'd19, 8'd9, 8'd7, 8'd5, 8'd3, 8'd1, 8'd0};
    kick(8'd199);
    run_coins(1'b0);

    // Zero amount completes immediately
    kick(8'd0);
    chk("zero_done", 32'(done), 1);
    chk("zero_busy", 32'(busy), 0);
    chk("zero_valid", 32'(out_valid), 0);
    step();
    chk("zero_done_clear", 32'(done), 0);
    chk("zero_valid2", 32'(out_valid), 0);

    // Hopper never acks: fault after ACK_TIMEOUT offer cycles
    kick(8'd20);
    step();
    chk("to_valid", 32'(out_valid), 1);
    chk("to_coin", 32'(out_coin), 32'(4'b1000));
    guard = 0;
    while (out_valid && guard < 200) begin
      step();
      guard++;
    end
    chk("timeout_len", 32'(guard), ACK_TIMEOUT);
    chk("to_fault", 32'(fault), 1);
    chk("to_busy", 32'(busy), 0);
    chk("to_coin0", 32'(out_coin), 0);
    chk("to_rem", 32'(remaining), 20);
    kick(8'd6);
    step();
    chk("fault_hold", 32'(fault), 1);
    chk("fault_start_busy", 32'(busy), 0);
    chk("fault_start_valid", 32'(out_valid), 0);
    chk("fault_rem_hold", 32'(remaining), 20);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_fault", 32'(fault), 0);
    chk("clear_rem", 32'(remaining), 0);
    chk("clear_busy", 32'(busy), 0);
    kick(8'd1);
    chk("post_clear_busy", 32'(busy), 1);

    // Ack on the very cycle the timeout would fire wins
    step();
    chk("late_valid", 32'(out_valid), 1);
    chk("late_coin", 32'(out_coin), 32'(4'b0001));
    for (int k = 0; k < ACK_TIMEOUT - 1; k++) step();
    chk("late_still_valid", 32'(out_valid), 1);
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
    chk("late_fault", 32'(fault), 0);
    chk("late_rem", 32'(remaining), 0);
    chk("late_valid_drop", 32'(out_valid), 0);
    wait_done();

    // Asynchronous reset mid-offer
    kick(8'd10);
    step();
    chk("ar_valid", 32'(out_valid), 1);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("async_rst");
    step();
    step();
    #2;
    reset = 1'b1;
    step();
    exp_coins = '{4'b0010, 4'b0010};
    exp_rem   = '{8'd4, 8'd2, 8'd0};
    kick(8'd4);
    run_coins(1'b0);

    // Stray start and ack during the gap are ignored
    exp_coins = '{4'b1000, 4'b0100, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
    exp_rem   = '{8'd37, 8'd17, 8'd7, 8'd5, 8'd3, 8'd1, 8'd0};
    kick(8'd37);
    run_coins(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
